// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for syn_fifo.
// NUM_REQ producers share the FIFO write port. Each grant lasts up to MAX_BURST accepted beats.
// One dead (IDLE) cycle separates grants. Writes are gated by full, so the FIFO never sees an
// overflow write.
// Optional feature macro: FIFO_WR_ARB_PRIO_EN. When it is defined, requester 0 wins every
// arbitration it takes part in, and requesters 1..NUM_REQ-1 round-robin among themselves.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 4,
  parameter int unsigned ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          full,
  output logic                          wr_en,
  output logic [DATA_WIDTH-1:0]         w_data,
  output logic                          gnt_active,
  output logic [ID_WIDTH-1:0]           gnt_id
);

  localparam int unsigned         CntWidth = $clog2(MAX_BURST) + 1;
  localparam logic [CntWidth-1:0] LastBeat = CntWidth'(MAX_BURST - 1);
  localparam logic [ID_WIDTH-1:0] LastId   = ID_WIDTH'(NUM_REQ - 1);

  // Reject unsupported configurations at elaboration time.
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("fifo_wr_arbiter: NUM_REQ must be in 2..8");
  end
  if (MAX_BURST < 1) begin : g_bad_max_burst
    $error("fifo_wr_arbiter: MAX_BURST must be >= 1");
  end

  typedef enum logic {
    StIdle,
    StBurst
  } state_e;

  state_e              state_q, state_d;
  logic [CntWidth-1:0] beat_cnt_q, beat_cnt_d;
  logic [ID_WIDTH-1:0] gnt_id_q, gnt_id_d;

  logic [DATA_WIDTH-1:0] req_slice [NUM_REQ];
  logic [NUM_REQ-1:0]    req_mask;
  logic [ID_WIDTH-1:0]   rr_base;
  logic [ID_WIDTH-1:0]   rr_winner;
  logic                  rr_found;
  logic [ID_WIDTH-1:0]   winner;
  logic                  any_req;
  logic                  xfer;
  int unsigned           cand;

  // Unpack the producer data bus into one word per requester.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign req_slice[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin search: the first set bit of req_mask, scanning upward from rr_base+1 and wrapping.
  // The scan covers rr_base itself last, so a lone requester can be re-granted.
  always_comb begin
    rr_found  = 1'b0;
    rr_winner = rr_base;
    cand      = 0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = (32'(rr_base) + off) % NUM_REQ;
      if (!rr_found && req_mask[ID_WIDTH'(cand)]) begin
        rr_found  = 1'b1;
        rr_winner = ID_WIDTH'(cand);
      end
    end
  end

`ifdef FIFO_WR_ARB_PRIO_EN
  // Requester 0 bypasses the ring. The ring pointer tracks only grants to 1..NUM_REQ-1, so
  // frequent grants to requester 0 do not disturb fairness among the others.
  logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;

  assign req_mask = {req_valid[NUM_REQ-1:1], 1'b0};
  assign rr_base  = rr_ptr_q;
  assign any_req  = req_valid[0] | rr_found;
  assign winner   = req_valid[0] ? '0 : rr_winner;

  // Advance the ring pointer only when a low-priority requester wins.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == StIdle && !req_valid[0] && rr_found) begin
      rr_ptr_d = rr_winner;
    end
  end

  // Ring pointer register; reset so that requester 1 leads the low-priority ring.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= LastId;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  // Pure round-robin over all requesters, anchored on the most recent grantee.
  assign req_mask = req_valid;
  assign rr_base  = gnt_id_q;
  assign any_req  = rr_found;
  assign winner   = rr_winner;
`endif

  // Next-state and output logic. The write path is purely combinational, so a beat is written to
  // the FIFO on the same edge that the producer sees it accepted.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    gnt_id_d   = gnt_id_q;
    req_ready  = '0;
    wr_en      = 1'b0;
    w_data     = '0;
    xfer       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          gnt_id_d   = winner;
          beat_cnt_d = '0;
          state_d    = StBurst;
        end
      end

      StBurst: begin
        req_ready[gnt_id_q] = ~full;
        xfer                = req_valid[gnt_id_q] & ~full;
        wr_en               = xfer;
        if (xfer) begin
          w_data = req_slice[gnt_id_q];
        end

        if (!req_valid[gnt_id_q]) begin
          // The grantee has run dry, so release the port early.
          state_d    = StIdle;
          beat_cnt_d = '0;
        end else if (xfer) begin
          if (beat_cnt_q == LastBeat) begin
            state_d    = StIdle;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
        // A stall on full holds both the grant and the beat count.
      end

      default: begin
        state_d    = StIdle;
        beat_cnt_d = '0;
      end
    endcase
  end

  // State registers. Reset puts gnt_id on the last requester, so requester 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      beat_cnt_q <= '0;
      gnt_id_q   <= LastId;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      gnt_id_q   <= gnt_id_d;
    end
  end

  assign gnt_active = (state_q == StBurst);
  assign gnt_id     = gnt_id_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter with a behavioural grant model.
module tb_fifo_wr_arbiter;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int MB  = 4;
  localparam int IDW = 2;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            full;
  logic            wr_en;
  logic [DW-1:0]   w_data;
  logic            gnt_active;
  logic [IDW-1:0]  gnt_id;

  fifo_wr_arbiter #(
    .NUM_REQ   (N),
    .DATA_WIDTH(DW),
    .MAX_BURST (MB),
    .ID_WIDTH  (IDW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .full      (full),
    .wr_en     (wr_en),
    .w_data    (w_data),
    .gnt_active(gnt_active),
    .gnt_id    (gnt_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Producer-side stimulus: each producer presents the head of its queue while not gapped.
  logic [DW-1:0] pq [N][$];
  logic [N-1:0]  gap;

  // Model of the arbiter: who holds the port, how many beats they have had, and the ring pointer.
  bit m_busy;
  int m_last;
  int m_beats;
  int m_ptr;

  // Expected and observed outputs for the current cycle.
  logic [N-1:0]   exp_ready, obs_ready;
  logic           exp_wr, obs_wr;
  logic [DW-1:0]  exp_data, obs_data;
  logic           exp_act, obs_act;
  logic [IDW-1:0] exp_id, obs_id;
  string          obs_s, exp_s;

  function automatic int pick_winner(input logic [N-1:0] v);
`ifdef FIFO_WR_ARB_PRIO_EN
    if (v[0]) return 0;
    for (int k = 1; k <= N; k++) begin
      int c = (m_ptr + k) % N;
      if (c != 0 && v[c]) return c;
    end
`else
    for (int k = 1; k <= N; k++) begin
      int c = (m_last + k) % N;
      if (v[c]) return c;
    end
`endif
    return -1;
  endfunction

  task automatic model_reset();
    m_busy  = 1'b0;
    m_last  = N - 1;
    m_beats = 0;
    m_ptr   = N - 1;
  endtask

  task automatic model_outputs();
    exp_ready = '0;
    exp_wr    = 1'b0;
    exp_data  = '0;
    exp_act   = m_busy;
    exp_id    = IDW'(m_last);
    if (m_busy && !full) begin
      exp_ready[m_last] = 1'b1;
      if (req_valid[m_last]) begin
        exp_wr   = 1'b1;
        exp_data = pq[m_last][0];
      end
    end
  endtask

  task automatic model_advance();
    if (!m_busy) begin
      int w = pick_winner(req_valid);
      if (w >= 0) begin
        m_busy  = 1'b1;
        m_last  = w;
        m_beats = 0;
        if (w != 0) m_ptr = w;
      end
    end else if (!req_valid[m_last]) begin
      m_busy  = 1'b0;
      m_beats = 0;
    end else if (!full) begin
      m_beats++;
      if (m_beats == MB) begin
        m_busy  = 1'b0;
        m_beats = 0;
      end
    end
  endtask

  task automatic apply_inputs();
    for (int i = 0; i < N; i++) begin
      req_valid[i]           = (pq[i].size() > 0) && !gap[i];
      req_data[i*DW +: DW]   = (pq[i].size() > 0) ? pq[i][0] : '0;
    end
  endtask

  // One clock: drive, sample at negedge, then at posedge retire handshakes and step the model.
  task automatic tick();
    apply_inputs();
    @(negedge clk);
    model_outputs();
    obs_ready = req_ready;
    obs_wr    = wr_en;
    obs_data  = w_data;
    obs_act   = gnt_active;
    obs_id    = gnt_id;
    obs_s = $sformatf("rdy=%b wr=%b d=%h act=%b id=%0d", obs_ready, obs_wr, obs_data, obs_act,
                      obs_id);
    exp_s = $sformatf("rdy=%b wr=%b d=%h act=%b id=%0d", exp_ready, exp_wr, exp_data, exp_act,
                      exp_id);
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (exp_ready[i] && req_valid[i]) void'(pq[i].pop_front());
    end
    model_advance();
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    full = 1'b0;
    gap  = '0;
    for (int i = 0; i < N; i++) pq[i].delete();
    apply_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    full      = 1'b0;
    gap       = '0;
    req_valid = '1;
    req_data  = '1;
    #3;
    n_tests++;
    if (req_ready !== '0) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 0", req_ready);
    end
    n_tests++;
    if (wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_wr_en: got %b want 0", wr_en);
    end
    n_tests++;
    if (w_data !== '0) begin
      n_fail++;
      $display("FAIL reset_w_data: got %h want 0", w_data);
    end
    n_tests++;
    if (gnt_active !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_gnt_active: got %b want 0", gnt_active);
    end
    n_tests++;
    if (gnt_id !== IDW'(N - 1)) begin
      n_fail++;
      $display("FAIL reset_gnt_id: got %0d want %0d", gnt_id, N - 1);
    end
    do_reset();
  endtask

  // Req 1 alone with 6 beats: 4 beats, dead cycle, 2 beats, then early release.
  task automatic test_single_burst();
    int pat [10] = '{-1, 'h11, 'h12, 'h13, 'h14, -1, 'h15, 'h16, -1, -1};
    do_reset();
    for (int k = 0; k < 6; k++) pq[1].push_back(DW'('h11 + k));
    for (int c = 0; c < 10; c++) begin
      tick();
      n_tests++;
      if ({obs_ready, obs_wr, obs_data, obs_act, obs_id} !==
          {exp_ready, exp_wr, exp_data, exp_act, exp_id}) begin
        n_fail++;
        $display("FAIL single_burst cyc %0d: got %s want %s", c, obs_s, exp_s);
      end
      n_tests++;
      if (obs_wr !== (pat[c] >= 0) || (pat[c] >= 0 && obs_data !== DW'(pat[c]))) begin
        n_fail++;
        $display("FAIL single_burst_seq cyc %0d: got wr=%b d=%h want pattern %0d", c, obs_wr,
                 obs_data, pat[c]);
      end
    end
    n_tests++;
    if (obs_act !== 1'b0 || obs_id !== IDW'(1)) begin
      n_fail++;
      $display("FAIL single_burst_end: got act=%b id=%0d want act=0 id=1", obs_act, obs_id);
    end
  endtask

  // All four producers always valid: grant order and 16 writes per round.
  task automatic test_round_robin();
    int grants [$];
    int wr_cnt;
    logic prev_act;
`ifdef FIFO_WR_ARB_PRIO_EN
    int want [5] = '{0, 0, 1, 2, 3};
`else
    int want [5] = '{0, 1, 2, 3, 0};
`endif
    do_reset();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 8; k++) pq[i].push_back(DW'(i * 16 + k));
    wr_cnt   = 0;
    prev_act = 1'b0;
    for (int c = 0; c < 24; c++) begin
      tick();
      n_tests++;
      if ({obs_ready, obs_wr, obs_data, obs_act, obs_id} !==
          {exp_ready, exp_wr, exp_data, exp_act, exp_id}) begin
        n_fail++;
        $display("FAIL round_robin cyc %0d: got %s want %s", c, obs_s, exp_s);
      end
      if (c < 20 && obs_wr) wr_cnt++;
      if (obs_act && !prev_act) grants.push_back(int'(obs_id));
      prev_act = obs_act;
    end
    n_tests++;
    if (wr_cnt !== 16) begin
      n_fail++;
      $display("FAIL round_robin_writes: got %0d want 16", wr_cnt);
    end
    for (int g = 0; g < 5; g++) begin
      n_tests++;
      if (g >= grants.size() || grants[g] !== want[g]) begin
        n_fail++;
        $display("FAIL round_robin_order grant %0d: got %0d want %0d", g,
                 (g < grants.size()) ? grants[g] : -1, want[g]);
      end
    end
  endtask

  // Req 2 stalls on full for 3 cycles after its second beat.
  task automatic test_full_stall();
    bit fsched [9] = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
    int stall_wr;
    int total_wr;
    do_reset();
    for (int k = 0; k < 4; k++) pq[2].push_back(DW'('h21 + k));
    stall_wr = 0;
    total_wr = 0;
    for (int c = 0; c < 9; c++) begin
      full = fsched[c];
      tick();
      n_tests++;
      if ({obs_ready, obs_wr, obs_data, obs_act, obs_id} !==
          {exp_ready, exp_wr, exp_data, exp_act, exp_id}) begin
        n_fail++;
        $display("FAIL full_stall cyc %0d: got %s want %s", c, obs_s, exp_s);
      end
      if (fsched[c] && (obs_wr || obs_ready[2])) stall_wr++;
      if (obs_wr) total_wr++;
    end
    full = 1'b0;
    n_tests++;
    if (stall_wr !== 0) begin
      n_fail++;
      $display("FAIL full_stall_gate: got %0d writes/readies while full want 0", stall_wr);
    end
    n_tests++;
    if (total_wr !== 4) begin
      n_fail++;
      $display("FAIL full_stall_total: got %0d writes want 4", total_wr);
    end
  endtask

  // Req 0 runs dry after 2 beats while req 3 waits.
  task automatic test_early_drop();
    int wr_early;
    do_reset();
    pq[0].push_back(8'h01);
    pq[0].push_back(8'h02);
    for (int k = 0; k < 4; k++) pq[3].push_back(DW'('h31 + k));
    wr_early = 0;
    for (int c = 0; c < 7; c++) begin
      tick();
      n_tests++;
      if ({obs_ready, obs_wr, obs_data, obs_act, obs_id} !==
          {exp_ready, exp_wr, exp_data, exp_act, exp_id}) begin
        n_fail++;
        $display("FAIL early_drop cyc %0d: got %s want %s", c, obs_s, exp_s);
      end
      if (c < 5 && obs_wr) wr_early++;
      if (c == 4) begin
        n_tests++;
        if (obs_act !== 1'b0) begin
          n_fail++;
          $display("FAIL early_drop_idle: got act=%b want 0", obs_act);
        end
      end
      if (c == 5) begin
        n_tests++;
        if (obs_act !== 1'b1 || obs_id !== IDW'(3)) begin
          n_fail++;
          $display("FAIL early_drop_regrant: got act=%b id=%0d want act=1 id=3", obs_act, obs_id);
        end
      end
    end
    n_tests++;
    if (wr_early !== 2) begin
      n_fail++;
      $display("FAIL early_drop_beats: got %0d writes want 2", wr_early);
    end
  endtask

  // Asynchronous reset between edges in the middle of a burst.
  task automatic test_reset_mid_burst();
    int first_gnt;
    do_reset();
    for (int k = 0; k < 6; k++) pq[1].push_back(DW'('h40 + k));
    for (int c = 0; c < 3; c++) begin
      tick();
      n_tests++;
      if ({obs_ready, obs_wr, obs_data, obs_act, obs_id} !==
          {exp_ready, exp_wr, exp_data, exp_act, exp_id}) begin
        n_fail++;
        $display("FAIL reset_mid_pre cyc %0d: got %s want %s", c, obs_s, exp_s);
      end
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({req_ready, wr_en, w_data, gnt_active} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got rdy=%b wr=%b d=%h act=%b want all 0", req_ready, wr_en,
               w_data, gnt_active);
    end
    do_reset();
    for (int k = 0; k < 3; k++) begin
      pq[0].push_back(DW'('h50 + k));
      pq[2].push_back(DW'('h70 + k));
    end
    first_gnt = -1;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_tests++;
      if ({obs_ready, obs_wr, obs_data, obs_act, obs_id} !==
          {exp_ready, exp_wr, exp_data, exp_act, exp_id}) begin
        n_fail++;
        $display("FAIL reset_mid_post cyc %0d: got %s want %s", c, obs_s, exp_s);
      end
      if (first_gnt < 0 && obs_act) first_gnt = int'(obs_id);
    end
    n_tests++;
    if (first_gnt !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_first_grant: got %0d want 0", first_gnt);
    end
  endtask

  // Reqs 0 and 2 valid after a grant to 0: priority build re-grants 0 first.
  task automatic test_priority();
    int grants [$];
    logic prev_act;
`ifdef FIFO_WR_ARB_PRIO_EN
    int want [3] = '{0, 0, 2};
`else
    int want [3] = '{0, 2, 0};
`endif
    do_reset();
    for (int k = 0; k < 6; k++) pq[0].push_back(DW'('h01 + k));
    for (int k = 0; k < 4; k++) pq[2].push_back(DW'('h21 + k));
    prev_act = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      n_tests++;
      if ({obs_ready, obs_wr, obs_data, obs_act, obs_id} !==
          {exp_ready, exp_wr, exp_data, exp_act, exp_id}) begin
        n_fail++;
        $display("FAIL priority cyc %0d: got %s want %s", c, obs_s, exp_s);
      end
      if (obs_act && !prev_act) grants.push_back(int'(obs_id));
      prev_act = obs_act;
    end
    for (int g = 0; g < 3; g++) begin
      n_tests++;
      if (g >= grants.size() || grants[g] !== want[g]) begin
        n_fail++;
        $display("FAIL priority_order grant %0d: got %0d want %0d", g,
                 (g < grants.size()) ? grants[g] : -1, want[g]);
      end
    end
  endtask

  // Random producers, gaps and full, checked every cycle against the model.
  task automatic test_random();
    int bad;
    do_reset();
    bad = 0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (pq[i].size() < 3 && $urandom_range(0, 2) == 0) pq[i].push_back(DW'($urandom));
        gap[i] = ($urandom_range(0, 7) == 0);
      end
      full = ($urandom_range(0, 3) == 0);
      tick();
      n_tests++;
      if ({obs_ready, obs_wr, obs_data, obs_act, obs_id} !==
          {exp_ready, exp_wr, exp_data, exp_act, exp_id}) begin
        n_fail++;
        bad++;
        if (bad <= 10) $display("FAIL random cyc %0d: got %s want %s", c, obs_s, exp_s);
      end
    end
    full = 1'b0;
    gap  = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_full_stall();
    test_early_drop();
    test_reset_mid_burst();
    test_priority();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
